// File: rtl/ifid_frontend_pkg.sv
// Shared pipeline constants for the fetch front end.
// Imported by the IF/ID register slice and its helpers.
package ifid_frontend_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_SQUASH,
        IFID_LOAD
    } ifid_op_e;

endpackage

// File: rtl/ifid_frontend_sat_counter.sv
// Saturating event counter with enable and async active-low clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    logic at_max;

    assign at_max = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && !at_max) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ifid_frontend.sv
// Fetch front end: PC register, IF/ID register and hazard control.
// Stall wins over flush so an unresolved branch cannot redirect.
module ifid_frontend
    import ifid_frontend_pkg::*;
#(
    parameter int                XLEN     = ifid_frontend_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             PCWrite_i,
    input  logic             Stall_i,
    input  logic             Flush_i,
    input  logic [XLEN-1:0]  BranchTarget_i,
    input  logic [ILEN-1:0]  Instr_i,
    output logic [XLEN-1:0]  InstrAddr_o,
    output logic [XLEN-1:0]  PC_o,
    output logic [XLEN-1:0]  IFID_PC_o,
    output logic [ILEN-1:0]  IFID_Instr_o,
    output logic             IFID_Valid_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o
);

    logic            stall_apply;
    logic            flush_apply;
    logic            pc_en;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] redirect;
    ifid_op_e        ifid_op;

    assign stall_apply = start_i & Stall_i;
    assign flush_apply = start_i & ~Stall_i & Flush_i;
    assign pc_en       = start_i & PCWrite_i;
    assign redirect    = {BranchTarget_i[XLEN-1:2], 2'b00};
    assign pc_next     = flush_apply ? redirect : pc_q + XLEN'(4);

    always_comb begin
        ifid_op = IFID_HOLD;
        unique case (1'b1)
            !start_i:    ifid_op = IFID_HOLD;
            stall_apply: ifid_op = IFID_HOLD;
            flush_apply: ifid_op = IFID_SQUASH;
            default:     ifid_op = IFID_LOAD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q <= RESET_PC;
        end else if (pc_en) begin
            pc_q <= pc_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            IFID_PC_o    <= '0;
            IFID_Instr_o <= NOP;
            IFID_Valid_o <= 1'b0;
        end else begin
            case (ifid_op)
                IFID_SQUASH: begin
                    IFID_PC_o    <= pc_q;
                    IFID_Instr_o <= NOP;
                    IFID_Valid_o <= 1'b0;
                end
                IFID_LOAD: begin
                    IFID_PC_o    <= pc_q;
                    IFID_Instr_o <= Instr_i;
                    IFID_Valid_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign PC_o        = pc_q;
    assign InstrAddr_o = pc_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (stall_apply),
        .cnt   (StallCnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk_i),
        .rst_n (rst_i),
        .en    (flush_apply),
        .cnt   (FlushCnt_o)
    );

endmodule

// File: tb/tb_ifid_frontend.sv
// Scoreboard bench for ifid_frontend with a 4-bit counter build.
// Expected state is queued at drive time and checked after the edge.
module tb_ifid_frontend;

    localparam int CNT_W = 4;
    localparam logic [31:0] NOP_W = 32'h0000_0013;
    localparam logic [3:0] CMAX = 4'hF;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifpc;
        logic [31:0] ifinstr;
        logic        valid;
        logic [3:0]  sc;
        logic [3:0]  fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic pcw = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    logic [31:0] tgt = '0;
    logic [31:0] instr;
    logic [31:0] iaddr;
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] ifinstr;
    logic        valid;
    logic [3:0]  scnt;
    logic [3:0]  fcnt;

    int checks = 0;
    int failures = 0;

    exp_t sb[$];
    exp_t m;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a ^ 32'hA5A5_0000) | 32'h3;
    endfunction

    assign instr = imem(iaddr);

    ifid_frontend #(.CNT_W(CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst_n),
        .start_i        (start),
        .PCWrite_i      (pcw),
        .Stall_i        (stall),
        .Flush_i        (flush),
        .BranchTarget_i (tgt),
        .Instr_i        (instr),
        .InstrAddr_o    (iaddr),
        .PC_o           (pc),
        .IFID_PC_o      (ifpc),
        .IFID_Instr_o   (ifinstr),
        .IFID_Valid_o   (valid),
        .StallCnt_o     (scnt),
        .FlushCnt_o     (fcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m.pc = 32'h0;
        m.ifpc = 32'h0;
        m.ifinstr = NOP_W;
        m.valid = 1'b0;
        m.sc = 4'h0;
        m.fc = 4'h0;
    endtask

    task automatic check_state(input string tag, input exp_t e);
        chk({tag, ".pc"}, pc, e.pc);
        chk({tag, ".addr"}, iaddr, e.pc);
        chk({tag, ".ifpc"}, ifpc, e.ifpc);
        chk({tag, ".instr"}, ifinstr, e.ifinstr);
        chk({tag, ".valid"}, {31'h0, valid}, {31'h0, e.valid});
        chk({tag, ".scnt"}, {28'h0, scnt}, {28'h0, e.sc});
        chk({tag, ".fcnt"}, {28'h0, fcnt}, {28'h0, e.fc});
    endtask

    task automatic step(input string tag, input logic st, input logic pw,
                        input logic sl, input logic fl,
                        input logic [31:0] t);
        exp_t n;
        exp_t got;
        @(negedge clk);
        start = st;
        pcw = pw;
        stall = sl;
        flush = fl;
        tgt = t;
        n = m;
        if (st) begin
            if (sl) begin
                if (m.sc != CMAX) n.sc = m.sc + 4'h1;
            end else if (fl) begin
                n.ifpc = m.pc;
                n.ifinstr = NOP_W;
                n.valid = 1'b0;
                if (m.fc != CMAX) n.fc = m.fc + 4'h1;
            end else begin
                n.ifpc = m.pc;
                n.ifinstr = imem(m.pc);
                n.valid = 1'b1;
            end
            if (pw) begin
                if (!sl && fl) n.pc = {t[31:2], 2'b00};
                else n.pc = m.pc + 32'd4;
            end
        end
        sb.push_back(n);
        m = n;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'h1, 32'h0);
        end else begin
            got = sb.pop_front();
            check_state(tag, got);
        end
    endtask

    initial begin
        model_reset();
        #12;
        check_state("reset", m);
        @(negedge clk);
        rst_n = 1'b1;

        step("seq0", 1, 1, 0, 0, 0);
        chk("seq0.pc4", pc, 32'h4);
        step("seq1", 1, 1, 0, 0, 0);
        step("ldst", 1, 0, 1, 0, 0);
        chk("ldst.pc", pc, 32'h8);
        chk("ldst.ifpc", ifpc, 32'h4);
        step("res0", 1, 1, 0, 0, 0);
        chk("res0.pc", pc, 32'hC);
        step("res1", 1, 1, 0, 0, 0);
        step("br", 1, 1, 0, 1, 32'h40);
        chk("br.pc", pc, 32'h40);
        chk("br.nop", ifinstr, NOP_W);
        step("br1", 1, 1, 0, 0, 0);
        chk("br1.ifpc", ifpc, 32'h40);
        step("stfl", 1, 0, 1, 1, 32'h80);
        chk("stfl.fc", {28'h0, fcnt}, 32'h1);
        step("unal", 1, 1, 0, 1, 32'h43);
        chk("unal.pc", pc, 32'h40);
        step("flnopc", 1, 0, 0, 1, 32'h100);
        step("idle", 0, 1, 1, 1, 32'h200);
        step("incons", 1, 1, 1, 0, 0);
        step("wrapbr", 1, 1, 0, 1, 32'hFFFF_FFFC);
        step("wrap", 1, 1, 0, 0, 0);
        chk("wrap.pc", pc, 32'h0);
        for (int i = 0; i < 12; i++) begin
            step("rnd", 1'($urandom_range(0, 1)) | 1'(i < 6),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom);
        end
        for (int i = 0; i < 20; i++) step("sat", 1, 0, 1, 0, 0);
        chk("sat.scnt", {28'h0, scnt}, 32'hF);

        @(negedge clk);
        start = 1'b1;
        pcw = 1'b0;
        stall = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state("midrst", m);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ifid_frontend.md
# ifid_frontend

Fetch-side front end for the 5-stage pipeline: owns the PC register and the IF/ID pipeline register and carries out the hazard controls generated downstream. It consumes PCWrite/Stall from load-use hazard detection and Flush from the ID-stage branch resolver. It also keeps saturating stall and flush event counters for performance debug. It sits between instruction memory and the ID stage.

## Interface
Parameters:
- XLEN, 32, datapath and PC width
- RESET_PC, 32'h0000_0000, PC value after reset
- CNT_W, 16, width of each event counter

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset, asynchronous, active-low
- start_i  in  1  run enable; when low the front end is frozen
- PCWrite_i  in  1  1 = PC may update this cycle
- Stall_i  in  1  1 = hold the IF/ID register
- Flush_i  in  1  1 = branch taken in ID: redirect the PC and squash the IF/ID contents
- BranchTarget_i  in  XLEN  redirect address, used when Flush_i is applied
- Instr_i  in  32  instruction word from instruction memory (combinational read)
- InstrAddr_o  out  XLEN  fetch address to instruction memory (= PC_o)
- PC_o  out  XLEN  current PC register
- IFID_PC_o  out  XLEN  PC of the instruction held in IF/ID
- IFID_Instr_o  out  32  instruction held in IF/ID
- IFID_Valid_o  out  1  1 = IF/ID holds a real instruction; 0 = bubble
- StallCnt_o  out  CNT_W  number of applied stall cycles
- FlushCnt_o  out  CNT_W  number of applied flushes

## Operation
- Reset (rst_i low, at any time, including mid-stall or mid-flush), applied asynchronously:
  - PC_o = RESET_PC
  - IFID_PC_o = 0
  - IFID_Instr_o = NOP (32'h0000_0013)
  - IFID_Valid_o = 0
  - StallCnt_o = 0, FlushCnt_o = 0
- start_i = 0: all registers hold and counters do not count. All control inputs are ignored.
- start_i = 1: decisions use the input values sampled at the clock edge.
  - Stall is applied (Stall_i = 1): the IF/ID register holds all three fields. Flush_i is ignored that cycle, because a branch whose operands are still hazarded must not resolve. StallCnt increments.
  - Flush is applied (Stall_i = 0, Flush_i = 1): IF/ID loads IFID_Instr = NOP, IFID_Valid = 0, IFID_PC = PC_o. FlushCnt increments.
  - Otherwise: IF/ID loads IFID_PC = PC_o, IFID_Instr = Instr_i, IFID_Valid = 1.
  - PC update when PCWrite_i = 1:
    - if a flush is applied, next PC = {BranchTarget_i[XLEN-1:2], 2'b00}
    - else next PC = PC_o + 4, modulo 2^XLEN (0xFFFF_FFFC wraps to 0x0000_0000)
  - PCWrite_i = 0: the PC holds, even when Flush_i = 1. In that case the IF/ID squash still occurs when Stall_i = 0.
- The PC and IF/ID updates are independent. An inconsistent input pair (PCWrite_i = 1 with Stall_i = 1) is executed literally: the PC advances and IF/ID holds.
- Counters saturate at 2^CNT_W − 1 and never wrap.

## Timing
- InstrAddr_o is purely combinational from the PC register. Instr_i must be valid in the same cycle.
- Fetch latency: the instruction at PC P appears on IFID_Instr_o one cycle after PC_o = P.
- Redirect latency:
  - Flush sampled at edge N: PC_o = target after edge N.
  - The target instruction is in IF/ID after edge N+1.
  - Exactly one bubble is inserted.
- Load-use stall: one cycle with PCWrite_i = 0 and Stall_i = 1 leaves the PC and IF/ID unchanged for that edge, so there is no fetch loss.
- Counter outputs are registered: each reflects the events up to and including the previous edge.
- Asynchronous reset assert takes effect immediately. Release is synchronous to the design: the first update happens at the first rising edge after rst_i goes high with start_i = 1.

## Structure
- Shared pipeline package holds:
  - XLEN
  - the NOP encoding 32'h0000_0013
  - the instruction width of 32
- One natural sub-module: sat_counter, a CNT_W-bit saturating incrementer with enable and asynchronous active-low clear. It is instantiated twice, for stalls and for flushes.
- The PC register and the IF/ID register stay inline in ifid_frontend.

## Test plan
- Reset and sequential fetch: reset, start_i = 1, Instr_i = f(addr), no hazards → PC_o = 0, 4, 8, 12. IFID_PC_o lags by one cycle. IFID_Valid_o goes 0 then 1. Counters stay 0.
- Load-use stall: at PC = 8, drive PCWrite_i = 0 and Stall_i = 1 for one cycle → PC_o stays 8 and IFID_PC_o stays 4 for that edge, then fetch resumes at 12. StallCnt_o = 1.
- Taken branch: Flush_i = 1 with BranchTarget_i = 0x40 at PC = 0x10 → the next cycle has PC_o = 0x40, IFID_Instr_o = 0x13, IFID_Valid_o = 0. The following cycle has IFID_PC_o = 0x40. FlushCnt_o = 1.
- Stall with flush together: Stall_i = 1, Flush_i = 1, PCWrite_i = 0 → no redirect, IF/ID held, StallCnt_o increments, FlushCnt_o is unchanged.
- Boundaries:
  - PC = 0xFFFF_FFFC advances to 0.
  - BranchTarget_i = 0x43 gives PC_o = 0x40.
  - With CNT_W = 4, 20 stall cycles give StallCnt_o = 15.
- Reset mid-operation: assert rst_i during a stall with counters non-zero → all outputs immediately return to their reset values without waiting for a clock edge.
